// File: rtl/limit_seq_pkg.sv
// Shared constants and state encoding for the limit sequencer.
// Optional build macro LIMIT_SEQ_LOOP_EN (see limit_sequencer.sv) does not affect this package.
package limit_seq_pkg;

    localparam int DEPTH_DEF   = 8;
    localparam int LIMIT_W_DEF = 21;
    localparam int REP_W_DEF   = 8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef enum logic [0:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN
    } state_e;

endpackage

// File: rtl/limit_sequencer_rise_detect.sv
// Single-flop rising-edge detector for the divider's slowclk output.
// Optional build macro LIMIT_SEQ_LOOP_EN does not affect this module.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic rise
);

    logic sig_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise = sig & ~sig_q;

endmodule

// File: rtl/limit_sequencer.sv
// Plays a table of divider limits, holding each for a programmed number of slowclk rises.
// Define LIMIT_SEQ_LOOP_EN to wrap to entry 0 at end of sequence instead of returning to idle.
module limit_sequencer
    import limit_seq_pkg::*;
#(
    parameter int                  DEPTH      = DEPTH_DEF,
    parameter int                  LIMIT_W    = LIMIT_W_DEF,
    parameter int                  REP_W      = REP_W_DEF,
    parameter logic [LIMIT_W-1:0]  IDLE_LIMIT = '0
) (
    input  logic                       clk_20k,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [LIMIT_W-1:0]         wr_limit,
    input  logic [REP_W-1:0]           wr_reps,
    input  logic [$clog2(DEPTH):0]     len,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       slowclk,
    output logic [LIMIT_W-1:0]         limit,
    output logic [$clog2(DEPTH)-1:0]   step,
    output logic                       busy,
    output logic                       done,
    output logic [0:0]                 fsm_state
);

    localparam int AW = $clog2(DEPTH);

    logic [LIMIT_W-1:0] tbl_limit [DEPTH];
    logic [REP_W-1:0]   tbl_reps  [DEPTH];

    logic [0:0]         state_q, state_n;
    logic [AW-1:0]      step_n;
    logic [LIMIT_W-1:0] limit_n;
    logic [REP_W-1:0]   rep_cnt, rep_n;
    logic [REP_W-1:0]   reps_q, reps_n;
    logic [AW:0]        len_q, len_n;
    logic               done_n;

    logic               rise;
    logic [REP_W-1:0]   reps_eff;
    logic               last_rep;
    logic               last_step;
    logic               load;
    logic [AW-1:0]      load_idx;

    rise_detect u_rise (
        .clk   (clk_20k),
        .rst_n (rst_n),
        .sig   (slowclk),
        .rise  (rise)
    );

    // Table is plain storage; a write only matters the next time its entry is loaded.
    always_ff @(posedge clk_20k) begin
        if (wr_en) begin
            tbl_limit[wr_addr] <= wr_limit;
            tbl_reps[wr_addr]  <= wr_reps;
        end
    end

    assign reps_eff  = (reps_q == '0) ? REP_W'(1) : reps_q;
    assign last_rep  = (rep_cnt == reps_eff - REP_W'(1));
    assign last_step = ({1'b0, step} == len_q - (AW+1)'(1));

    always_comb begin
        state_n  = state_q;
        step_n   = step;
        limit_n  = limit;
        rep_n    = rep_cnt;
        reps_n   = reps_q;
        len_n    = len_q;
        done_n   = 1'b0;
        load     = 1'b0;
        load_idx = '0;

        // stop wins over start and over end-of-sequence.
        if (stop) begin
            state_n = ST_IDLE;
            limit_n = IDLE_LIMIT;
            step_n  = '0;
            rep_n   = '0;
        end else if (state_q == ST_IDLE) begin
            if (start && (len != '0)) begin
                state_n  = ST_RUN;
                len_n    = len;
                load     = 1'b1;
                load_idx = '0;
            end
        end else if (rise) begin
            if (last_rep) begin
                if (last_step) begin
                    done_n = 1'b1;
`ifdef LIMIT_SEQ_LOOP_EN
                    load     = 1'b1;
                    load_idx = '0;
`else
                    state_n = ST_IDLE;
                    limit_n = IDLE_LIMIT;
                    step_n  = '0;
                    rep_n   = '0;
`endif
                end else begin
                    load     = 1'b1;
                    load_idx = step + AW'(1);
                end
            end else begin
                rep_n = rep_cnt + REP_W'(1);
            end
        end

        if (load) begin
            step_n  = load_idx;
            limit_n = tbl_limit[load_idx];
            reps_n  = tbl_reps[load_idx];
            rep_n   = '0;
        end
    end

    always_ff @(posedge clk_20k or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            step    <= '0;
            limit   <= IDLE_LIMIT;
            rep_cnt <= '0;
            reps_q  <= '0;
            len_q   <= '0;
            done    <= 1'b0;
        end else begin
            state_q <= state_n;
            step    <= step_n;
            limit   <= limit_n;
            rep_cnt <= rep_n;
            reps_q  <= reps_n;
            len_q   <= len_n;
            done    <= done_n;
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign fsm_state = state_q;

endmodule

// File: tb/tb_limit_sequencer.sv
// Randomized bench for limit_sequencer: a step-level model predicts every output change
// (cycle, limit, step, busy, done); a monitor compares each change the DUT presents.
module tb_limit_sequencer;

    localparam int DEPTH   = 8;
    localparam int LIMIT_W = 21;
    localparam int REP_W   = 8;
    localparam int AW      = 3;
    localparam int EW      = 32 + LIMIT_W + AW + 2;

    logic               clk_20k = 1'b0;
    logic               rst_n   = 1'b0;
    logic               wr_en   = 1'b0;
    logic [AW-1:0]      wr_addr = '0;
    logic [LIMIT_W-1:0] wr_limit = '0;
    logic [REP_W-1:0]   wr_reps = '0;
    logic [AW:0]        len     = '0;
    logic               start   = 1'b0;
    logic               stop    = 1'b0;
    logic               slowclk = 1'b0;
    logic [LIMIT_W-1:0] limit;
    logic [AW-1:0]      step;
    logic               busy;
    logic               done;
    logic [0:0]         fsm_state;

    limit_sequencer dut (
        .clk_20k   (clk_20k),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_limit  (wr_limit),
        .wr_reps   (wr_reps),
        .len       (len),
        .start     (start),
        .stop      (stop),
        .slowclk   (slowclk),
        .limit     (limit),
        .step      (step),
        .busy      (busy),
        .done      (done),
        .fsm_state (fsm_state)
    );

    always #25 clk_20k = ~clk_20k;

    int cyc = 0;
    always @(posedge clk_20k) cyc <= cyc + 1;

    logic [EW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: sequence position and rises still owed on the current entry.
    bit                 m_run = 1'b0;
    int                 m_step = 0;
    int                 m_len = 0;
    int                 m_left = 0;
    logic [LIMIT_W-1:0] m_limit = '0;
    bit                 m_slow_q = 1'b0;
    int                 tbl_l[DEPTH];
    int                 tbl_r[DEPTH];

    function automatic void m_load(int i);
        m_step  = i;
        m_limit = tbl_l[i][LIMIT_W-1:0];
        m_left  = (tbl_r[i] == 0) ? 1 : tbl_r[i];
    endfunction

    task automatic model_edge();
        bit                 rise, d, changed;
        logic [LIMIT_W-1:0] p_l;
        int                 p_s;
        bit                 p_b;
        logic [31:0]        ec;
        logic [AW-1:0]      es;
        p_l = m_limit; p_s = m_step; p_b = m_run; d = 1'b0;
        rise = slowclk && !m_slow_q;
        m_slow_q = slowclk;
        if (stop) begin
            m_run = 1'b0; m_limit = '0; m_step = 0;
        end else if (!m_run) begin
            if (start && len != 0) begin
                m_run = 1'b1; m_len = int'(len); m_load(0);
            end
        end else if (rise) begin
            m_left--;
            if (m_left == 0) begin
                if (m_step == m_len - 1) begin
                    d = 1'b1;
`ifdef LIMIT_SEQ_LOOP_EN
                    m_load(0);
`else
                    m_run = 1'b0; m_limit = '0; m_step = 0;
`endif
                end else begin
                    m_load(m_step + 1);
                end
            end
        end
        if (wr_en) begin
            tbl_l[wr_addr] = int'(wr_limit);
            tbl_r[wr_addr] = int'(wr_reps);
        end
        changed = (m_limit != p_l) || (m_step != p_s) || (m_run != p_b);
        if (changed || d) begin
            ec = cyc + 1;
            es = m_step[AW-1:0];
            exp_q.push_back({ec, m_limit, es, m_run, d});
        end
    endtask

    // Monitor: every visible output change must match the next predicted event.
    logic [LIMIT_W-1:0] p_limit;
    logic [AW-1:0]      p_step;
    logic               p_busy;
    always @(negedge clk_20k) begin
        logic [EW-1:0] got, e;
        logic [31:0]   gc;
        if (!rst_n) begin
            p_limit = '0; p_step = '0; p_busy = 1'b0;
        end else begin
            if (limit !== p_limit || step !== p_step || busy !== p_busy || done !== 1'b0) begin
                gc = cyc;
                got = {gc, limit, step, busy, done};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event cyc=%0d limit=%0d step=%0d busy=%0b done=%0b required=no change",
                             gc, limit, step, busy, done);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL event got cyc=%0d limit=%0d step=%0d busy=%0b done=%0b required cyc=%0d limit=%0d step=%0d busy=%0b done=%0b",
                                 got[EW-1 -: 32], got[LIMIT_W+AW+1 -: LIMIT_W], got[AW+1 -: AW], got[1], got[0],
                                 e[EW-1 -: 32], e[LIMIT_W+AW+1 -: LIMIT_W], e[AW+1 -: AW], e[1], e[0]);
                    end
                end
            end
            p_limit = limit; p_step = step; p_busy = busy;
        end
    end

    task automatic chk(string name, logic [31:0] got, logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk_20k);
        @(negedge clk_20k);
    endtask

    // Divider-like slowclk: square wave with a random half period of 1..3 cycles.
    int sc_cnt = 1;
    task automatic cycle_io();
        sc_cnt--;
        if (sc_cnt <= 0) begin
            slowclk = ~slowclk;
            sc_cnt = $urandom_range(1, 3);
        end
        tick();
    endtask

    task automatic write_entry(int a, int l, int r);
        wr_en = 1'b1; wr_addr = a[AW-1:0]; wr_limit = l[LIMIT_W-1:0]; wr_reps = r[REP_W-1:0];
        cycle_io();
        wr_en = 1'b0;
    endtask

    task automatic pulse_start(int n);
        len = n[AW:0]; start = 1'b1;
        cycle_io();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        cycle_io();
        stop = 1'b0;
    endtask

    task automatic run_until_idle(int budget);
        for (int i = 0; i < budget && m_run; i++) cycle_io();
    endtask

    task automatic run_until_step(int s, int budget);
        for (int i = 0; i < budget && m_run && m_step != s; i++) cycle_io();
    endtask

    task automatic reset_mid_run();
        start = 1'b0; stop = 1'b0; wr_en = 1'b0;
        #5 rst_n = 1'b0;
        #1;
        chk("rst_limit", 32'(limit), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_step", 32'(step), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(negedge clk_20k);
        #5 rst_n = 1'b1;
        m_run = 1'b0; m_limit = '0; m_step = 0; m_slow_q = 1'b0;
        @(negedge clk_20k);
    endtask

    initial begin
        repeat (2) @(negedge clk_20k);
        chk("reset_limit", 32'(limit), 32'd0);
        chk("reset_step", 32'(step), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk_20k);

        for (int a = 0; a < DEPTH; a++) write_entry(a, $urandom_range(1, 2000), $urandom_range(0, 3));

        // Three-step table played once.
        write_entry(0, 100, 2);
        write_entry(1, 50, 1);
        write_entry(2, 10, 3);
        pulse_start(3);
        run_until_idle(300);
        repeat (3) cycle_io();

        // len of zero is ignored.
        len = '0; start = 1'b1;
        repeat (4) cycle_io();
        start = 1'b0;
        chk("len0_busy", 32'(busy), 32'd0);
        chk("len0_limit", 32'(limit), 32'd0);

        // Abort during step 1.
        pulse_start(3);
        run_until_step(1, 300);
        pulse_stop();
        repeat (4) cycle_io();

        // start and stop together from idle.
        len = 3; start = 1'b1; stop = 1'b1;
        cycle_io();
        start = 1'b0; stop = 1'b0;
        cycle_io();
        chk("start_stop_busy", 32'(busy), 32'd0);

        // Reset while running.
        pulse_start(3);
        repeat (4) cycle_io();
        reset_mid_run();
        repeat (2) cycle_io();

        // Two-entry table with reps=0 on entry 0, rewritten while step 1 plays.
        write_entry(0, 7, 0);
        write_entry(1, 9, 2);
        pulse_start(2);
        run_until_step(1, 300);
        write_entry(0, 99, 1);
        repeat (40) cycle_io();
        pulse_stop();
        repeat (3) cycle_io();

        // Randomized scenarios.
        for (int s = 0; s < 40; s++) begin
            int nw, ncyc;
            nw = $urandom_range(1, 4);
            for (int k = 0; k < nw; k++)
                write_entry($urandom_range(0, DEPTH-1), $urandom_range(0, 4000), $urandom_range(0, 3));
            pulse_start($urandom_range(0, DEPTH));
            ncyc = $urandom_range(20, 150);
            for (int i = 0; i < ncyc; i++) begin
                wr_en = ($urandom_range(0, 9) == 0);
                if (wr_en) begin
                    wr_addr = AW'($urandom_range(0, DEPTH-1));
                    wr_limit = LIMIT_W'($urandom_range(0, 4000));
                    wr_reps = REP_W'($urandom_range(0, 3));
                end
                stop = ($urandom_range(0, 59) == 0);
                start = ($urandom_range(0, 19) == 0);
                if (start) len = (AW+1)'($urandom_range(0, DEPTH));
                cycle_io();
            end
            wr_en = 1'b0; start = 1'b0; stop = 1'b0;
            pulse_stop();
            repeat (2) cycle_io();
        end

        repeat (4) cycle_io();
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL missing_events got=0 required=%0d", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
